// File: rtl/eg_pkg.sv
// Shared types and helpers for the ADSR envelope engine and its slot state store.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: eg_state_t (envelope phase), eg_rec_t (per-slot record),
// EG_LVL_MAX (silent attenuation), eg_rate_sat (rate + key-scale saturation).
package eg_pkg;

   localparam int EG_LVL_W  = 7;                   // integer attenuation bits
   localparam int EG_FRAC_W = 6;                   // fractional attenuation bits
   localparam int EG_W      = EG_LVL_W + EG_FRAC_W;

   typedef enum logic [2:0] {
      ATTACK,
      DECAY,
      SUSTAIN,
      RELEASE,
      FINISH
   } eg_state_t;

   typedef struct packed {
      eg_state_t         state;
      logic [EG_W-1:0]   level;
   } eg_rec_t;

   // All-ones attenuation means silence.
   localparam logic [EG_W-1:0] EG_LVL_MAX = '1;

   localparam eg_rec_t EG_REC_RESET = '{state: FINISH, level: EG_LVL_MAX};

   // Effective rate: a zero rate stays zero (envelope frozen), otherwise the
   // key-scale offset is added and the result clamps at 15.
   function automatic logic [3:0] eg_rate_sat(input logic [3:0] rate,
                                              input logic [1:0] ksr);
      logic [4:0] sum;
      sum = {1'b0, rate} + {3'b000, ksr};
      if (rate == 4'd0) begin
         return 4'd0;
      end
      return sum[4] ? 4'hF : sum[3:0];
   endfunction

endpackage

// File: rtl/eg_state_ram.sv
// Per-slot envelope record store: one write port, one registered read port.
// Latency: read data appears one enabled clock after rd_en; writes land on the enabled edge.
// Backpressure: none; the caller owns sequencing and never reads and writes one slot together.
//
// Ports: clk, reset_n (async, active low; every record returns to FINISH/all-ones),
//        rd_en/rd_addr -> rd_dat (registered), wr_en/wr_addr/wr_dat.
module eg_state_ram
   import eg_pkg::*;
#(
   parameter  int NUM_SLOTS = 18,
   localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rd_en,
   input  logic [SLOT_W-1:0] rd_addr,
   output eg_rec_t           rd_dat,
   input  logic              wr_en,
   input  logic [SLOT_W-1:0] wr_addr,
   input  eg_rec_t           wr_dat
);

   eg_rec_t mem [NUM_SLOTS];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            mem[i] <= EG_REC_RESET;
         end
         rd_dat <= EG_REC_RESET;
      end else begin
         if (wr_en) begin
            mem[wr_addr] <= wr_dat;
         end
         if (rd_en) begin
            rd_dat <= mem[rd_addr];
         end
      end
   end

endmodule

// File: rtl/adsr_envelope_engine.sv
// Time-multiplexed ADSR envelope engine: one shared datapath serving NUM_SLOTS operator slots.
// Latency: slot read at stage 0, rate chosen at stage 1, egout/egout_vld registered at stage 2.
// Backpressure: none; clkena low freezes every register, including the AM LFO.
//
// Ports: clk, reset_n (async active low), clkena, slot, stage (0..3), key (sampled at stage 2),
//        sus_en (sampled at stage 1), am, tl, ar, dr, sl, rr, rks -> egout (attenuation,
//        0 = loudest), egout_vld (one clkena cycle per serviced slot).
// Optional feature: define EG_AM_LFO_EN to add the triangle amplitude LFO gated by am;
// without it am is ignored and no LFO logic exists.
module adsr_envelope_engine
   import eg_pkg::*;
#(
   parameter  int NUM_SLOTS = 18,
   parameter  int LVL_W     = EG_LVL_W,   // must match the record width in eg_pkg
   parameter  int FRAC_W    = EG_FRAC_W,
   localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clkena,
   input  logic [SLOT_W-1:0] slot,
   input  logic [1:0]        stage,
   input  logic              key,
   input  logic              sus_en,
   input  logic              am,
   input  logic [LVL_W-1:0]  tl,
   input  logic [3:0]        ar,
   input  logic [3:0]        dr,
   input  logic [3:0]        sl,
   input  logic [3:0]        rr,
   input  logic [3:0]        rks,
   output logic [EG_W-1:0]   egout,
   output logic              egout_vld
);

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

   logic              slot_ok;
   logic [SLOT_W-1:0] slot_q;     // slot captured at stage 0, used for write-back
   logic              act_q;      // captured slot is in range
   logic [3:0]        rm_q;       // effective rate chosen at stage 1
   logic              lastkey [NUM_SLOTS];

   eg_rec_t           rd_dat;
   eg_rec_t           wr_dat;
   logic              rd_en;
   logic              wr_en;

   assign slot_ok = (slot <= LAST_SLOT);
   assign rd_en   = clkena && (stage == 2'd0) && slot_ok;
   assign wr_en   = clkena && (stage == 2'd2) && act_q;

   eg_state_ram #(
      .NUM_SLOTS (NUM_SLOTS)
   ) u_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .rd_en   (rd_en),
      .rd_addr (slot),
      .rd_dat  (rd_dat),
      .wr_en   (wr_en),
      .wr_addr (slot_q),
      .wr_dat  (wr_dat)
   );

   // ---------------- stage 1: rate select ----------------
   logic [3:0] rate_sel;

   always_comb begin
      rate_sel = 4'd0;
      case (rd_dat.state)
         ATTACK:  rate_sel = ar;
         DECAY:   rate_sel = dr;
         SUSTAIN: rate_sel = sus_en ? 4'd0 : rr;
         RELEASE: rate_sel = rr;
         default: rate_sel = 4'd0;
      endcase
   end

   // ---------------- stage 2: level update ----------------
   logic [EG_W-1:0] lvl_cur;
   logic [2:0]      step_base;    // {1, rks[1:0]}: 4..7 LSBs per step
   logic [EG_W-1:0] att_shift;
   logic [EG_W:0]   att_dec;
   logic [EG_W-1:0] att_lvl;
   logic [EG_W+4:0] rise_inc;
   logic [EG_W+5:0] rise_sum;
   logic [EG_W-1:0] rise_lvl;
   eg_state_t       nxt_state;
   logic [EG_W-1:0] nxt_lvl;
   logic            lk;

   assign lvl_cur   = rd_dat.level;
   assign step_base = {1'b1, rks[1:0]};

   // Attack is exponential: the step shrinks with the level, plus a small constant so it
   // always reaches zero. Only used for rm 1..14, so the shift is 1..14.
   assign att_shift = lvl_cur >> (4'd15 - rm_q);
   assign att_dec   = {1'b0, att_shift} + {{(EG_W-2){1'b0}}, step_base};
   assign att_lvl   = ({1'b0, lvl_cur} > att_dec) ? (lvl_cur - att_dec[EG_W-1:0]) : '0;

   // Linear rise shared by Decay, unsustained Sustain and Release; only used when rm != 0.
   assign rise_inc  = {{(EG_W+2){1'b0}}, step_base} << (rm_q - 4'd1);
   assign rise_sum  = {6'b000000, lvl_cur} + {1'b0, rise_inc};
   assign rise_lvl  = (|rise_sum[EG_W+5:EG_W]) ? EG_LVL_MAX : rise_sum[EG_W-1:0];

   assign lk = lastkey[slot_q];

   always_comb begin
      nxt_state = rd_dat.state;
      nxt_lvl   = lvl_cur;
      case (rd_dat.state)
         ATTACK: begin
            if (rm_q != 4'd0) begin
               nxt_lvl = (rm_q == 4'hF) ? '0 : att_lvl;
               if (nxt_lvl == '0) begin
                  nxt_state = DECAY;
               end
            end
         end
         DECAY: begin
            if (rm_q != 4'd0) begin
               nxt_lvl = rise_lvl;
            end
            if (nxt_lvl[EG_W-1 -: 4] >= sl) begin
               nxt_state = SUSTAIN;
            end
         end
         SUSTAIN: begin
            // Rate is forced to zero at stage 1 when sus_en holds the tone.
            if (rm_q != 4'd0) begin
               nxt_lvl = rise_lvl;
               if (nxt_lvl == EG_LVL_MAX) begin
                  nxt_state = FINISH;
               end
            end
         end
         RELEASE: begin
            if (rm_q != 4'd0) begin
               nxt_lvl = rise_lvl;
            end
            if (nxt_lvl == EG_LVL_MAX) begin
               nxt_state = FINISH;
            end
         end
         default: begin
            nxt_state = FINISH;
            nxt_lvl   = EG_LVL_MAX;
         end
      endcase

      // Key edges win over the rate step; retrigger keeps the current level.
      if (key && !lk) begin
         nxt_state = ATTACK;
      end else if (!key && lk && (nxt_state != FINISH)) begin
         nxt_state = RELEASE;
      end
   end

   always_comb begin
      wr_dat       = EG_REC_RESET;
      wr_dat.state = nxt_state;
      wr_dat.level = nxt_lvl;
   end

   // ---------------- amplitude LFO ----------------
   logic [9:0] am_term;

`ifdef EG_AM_LFO_EN
   // Up/down counter between 0 and 0xA0000 so the top 10 bits peak at 0x280 (~4.8 dB).
   // Step 98 gives a period of about 13.4k clkena cycles (~3.7 Hz at 49.7 kHz).
   localparam logic [19:0] LFO_PEAK = 20'hA0000;
   localparam logic [19:0] LFO_STEP = 20'd98;

   logic [19:0] lfo_cnt;
   logic        lfo_up;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfo_cnt <= '0;
         lfo_up  <= 1'b1;
      end else if (clkena) begin
         if (lfo_up) begin
            if (lfo_cnt >= LFO_PEAK - LFO_STEP) begin
               lfo_cnt <= LFO_PEAK;
               lfo_up  <= 1'b0;
            end else begin
               lfo_cnt <= lfo_cnt + LFO_STEP;
            end
         end else begin
            if (lfo_cnt <= LFO_STEP) begin
               lfo_cnt <= '0;
               lfo_up  <= 1'b1;
            end else begin
               lfo_cnt <= lfo_cnt - LFO_STEP;
            end
         end
      end
   end

   assign am_term = am ? lfo_cnt[19:10] : 10'd0;
`else
   logic unused_am;
   assign unused_am = am;
   assign am_term   = 10'd0;
`endif

   // ---------------- output limiter ----------------
   logic [EG_W+1:0] out_sum;

   assign out_sum = {2'b00, tl, {FRAC_W{1'b0}}}
                  + {2'b00, nxt_lvl}
                  + {{(EG_W-8){1'b0}}, am_term};

   // ---------------- pipeline registers ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot_q    <= '0;
         act_q     <= 1'b0;
         rm_q      <= 4'd0;
         egout     <= EG_LVL_MAX;
         egout_vld <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            lastkey[i] <= 1'b0;
         end
      end else if (clkena) begin
         egout_vld <= 1'b0;
         case (stage)
            2'd0: begin
               act_q <= slot_ok;
               if (slot_ok) begin
                  slot_q <= slot;
               end
            end
            2'd1: begin
               rm_q <= eg_rate_sat(rate_sel, rks[3:2]);
            end
            2'd2: begin
               if (act_q) begin
                  egout           <= (|out_sum[EG_W+1:EG_W]) ? EG_LVL_MAX : out_sum[EG_W-1:0];
                  egout_vld       <= 1'b1;
                  lastkey[slot_q] <= key;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_adsr_envelope_engine.sv
// Scoreboard bench for adsr_envelope_engine: scripted and random per-slot envelopes,
// an out-of-range slot every frame, random clkena gaps and a mid-frame reset.
module tb_adsr_envelope_engine;

   localparam int NSLOT   = 18;
   localparam int EGMAX   = 8191;
   localparam int NF_MAIN = 280;
   localparam int NF_POST = 30;
   localparam int BAD_ID  = 20;

   localparam int S_ATT = 0;
   localparam int S_DEC = 1;
   localparam int S_SUS = 2;
   localparam int S_REL = 3;
   localparam int S_FIN = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        clkena = 1'b0;
   logic [4:0]  slot = '0;
   logic [1:0]  stage = '0;
   logic        key = 1'b0;
   logic        sus_en = 1'b0;
   logic        am = 1'b0;
   logic [6:0]  tl = '0;
   logic [3:0]  ar = '0, dr = '0, sl = '0, rr = '0, rks = '0;
   logic [12:0] egout;
   logic        egout_vld;

   adsr_envelope_engine dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .clkena    (clkena),
      .slot      (slot),
      .stage     (stage),
      .key       (key),
      .sus_en    (sus_en),
      .am        (am),
      .tl        (tl),
      .ar        (ar),
      .dr        (dr),
      .sl        (sl),
      .rr        (rr),
      .rks       (rks),
      .egout     (egout),
      .egout_vld (egout_vld)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // per-slot stimulus parameters
   int p_ar[NSLOT], p_dr[NSLOT], p_sl[NSLOT], p_rr[NSLOT], p_rks[NSLOT];
   int p_tl[NSLOT], p_sus[NSLOT], p_key[NSLOT], p_am[NSLOT];

   // reference model state
   int m_st[NSLOT], m_lvl[NSLOT], m_lk[NSLOT];

   int exp_q[$];
   int exp_slot_q[$];

   logic upd = 1'b0;
   always @(posedge clk) upd = clkena;

   function automatic void model_reset();
      for (int s = 0; s < NSLOT; s++) begin
         m_st[s]  = S_FIN;
         m_lvl[s] = EGMAX;
         m_lk[s]  = 0;
      end
   endfunction

   function automatic int rise(int lvl, int base, int rm);
      int v;
      v = lvl + base * (1 << (rm - 1));
      return (v > EGMAX) ? EGMAX : v;
   endfunction

   // One envelope update for slot s, straight from the envelope rules; returns expected egout.
   function automatic int model_step(int s);
      int rate, rm, base, lvl, st, sum;
      st  = m_st[s];
      lvl = m_lvl[s];
      case (st)
         S_ATT:   rate = p_ar[s];
         S_DEC:   rate = p_dr[s];
         S_SUS:   rate = p_sus[s] ? 0 : p_rr[s];
         S_REL:   rate = p_rr[s];
         default: rate = 0;
      endcase
      rm = (rate == 0) ? 0 : rate + p_rks[s] / 4;
      if (rm > 15) rm = 15;
      base = 4 + p_rks[s] % 4;
      case (st)
         S_ATT: if (rm != 0) begin
            if (rm == 15) lvl = 0;
            else lvl = lvl - ((lvl >> (15 - rm)) + base);
            if (lvl < 0) lvl = 0;
            if (lvl == 0) st = S_DEC;
         end
         S_DEC: begin
            if (rm != 0) lvl = rise(lvl, base, rm);
            if (lvl / 512 >= p_sl[s]) st = S_SUS;
         end
         S_SUS: if (rm != 0) begin
            lvl = rise(lvl, base, rm);
            if (lvl == EGMAX) st = S_FIN;
         end
         S_REL: begin
            if (rm != 0) lvl = rise(lvl, base, rm);
            if (lvl == EGMAX) st = S_FIN;
         end
         default: lvl = EGMAX;
      endcase
      if (p_key[s] != 0 && m_lk[s] == 0) st = S_ATT;
      else if (p_key[s] == 0 && m_lk[s] != 0 && st != S_FIN) st = S_REL;
      m_lk[s]  = p_key[s];
      m_st[s]  = st;
      m_lvl[s] = lvl;
      sum = p_tl[s] * 64 + lvl;
      return (sum > EGMAX) ? EGMAX : sum;
   endfunction

   task automatic set_scn(input int s, input int a, input int d, input int l, input int r,
                          input int k, input int su, input int t, input int ky);
      p_ar[s] = a; p_dr[s] = d; p_sl[s] = l; p_rr[s] = r;
      p_rks[s] = k; p_sus[s] = su; p_tl[s] = t; p_key[s] = ky;
   endtask

   task automatic set_frame_params(input int f, input bit all_rand);
      for (int s = 0; s < NSLOT; s++) begin
`ifdef EG_AM_LFO_EN
         p_am[s] = 0;
`else
         p_am[s] = $urandom_range(0, 1);
`endif
         if (f % 25 == 0) begin
            p_ar[s]  = $urandom_range(0, 15);
            p_dr[s]  = $urandom_range(0, 15);
            p_sl[s]  = $urandom_range(0, 15);
            p_rr[s]  = $urandom_range(0, 15);
            p_rks[s] = $urandom_range(0, 15);
            p_sus[s] = $urandom_range(0, 1);
            p_tl[s]  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 16);
         end
         if ($urandom_range(0, 7) == 0) p_key[s] = (p_key[s] == 0) ? 1 : 0;
      end
      if (!all_rand) begin
         set_scn(0, 15, 0, 15, 0, 0, 1, 0, (f >= 2) ? 1 : 0);
         set_scn(3, 8, 4, 5, 0, 8, 1, 0, (f >= 1) ? 1 : 0);
         set_scn(4, 8, 4, 5, 6, 8, 0, 0, (f >= 1) ? 1 : 0);
         set_scn(5, 12, 4, 15, 15, 4, 1, 0, (f >= 1 && !(f >= 40 && f < 44)) ? 1 : 0);
         set_scn(6, 10, 6, 15, 3, 0, 1, 0, ((f >= 1 && f < 60) || f >= 90) ? 1 : 0);
         set_scn(7, 14, 2, 15, 2, 0, 1, 127, (f >= 1) ? 1 : 0);
      end
   endtask

   task automatic drive_slot(input int id);
      slot = 5'(id);
      if (id < NSLOT) begin
         key = p_key[id][0]; sus_en = p_sus[id][0]; am = p_am[id][0];
         tl = 7'(p_tl[id]); ar = 4'(p_ar[id]); dr = 4'(p_dr[id]);
         sl = 4'(p_sl[id]); rr = 4'(p_rr[id]); rks = 4'(p_rks[id]);
      end else begin
         key = 1'($urandom_range(0, 1)); sus_en = 1'($urandom_range(0, 1)); am = 1'b1;
         tl = 7'($urandom_range(0, 127)); ar = 4'($urandom_range(0, 15)); dr = 4'hF;
         sl = 4'h0; rr = 4'hF; rks = 4'($urandom_range(0, 15));
      end
   endtask

   task automatic tick(input int st);
      stage = 2'(st);
      while ($urandom_range(0, 7) == 0) begin
         clkena = 1'b0;
         @(posedge clk); #1;
      end
      clkena = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      @(negedge clk);
      n_chk++;
      if (egout !== 13'h1FFF) begin
         n_fail++; $display("FAIL reset_mid_egout: got %h, need 1fff", egout);
      end
      n_chk++;
      if (egout_vld !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid_vld: got %b, need 0", egout_vld);
      end
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL reset_mid_pending: %0d outputs missing, need 0", exp_q.size());
      end
      exp_q.delete();
      exp_slot_q.delete();
      model_reset();
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   // Services every slot plus one out-of-range slot; optional reset after stage 1 of inject_slot.
   task automatic run_frame(input int inject_slot);
      for (int s = 0; s <= NSLOT; s++) begin
         int id;
         id = (s == NSLOT) ? BAD_ID : s;
         drive_slot(id);
         for (int st = 0; st < 4; st++) begin
            if (st == 2 && id < NSLOT) begin
               exp_q.push_back(model_step(id));
               exp_slot_q.push_back(id);
            end
            tick(st);
            if (id == inject_slot && st == 1) begin
               do_reset();
               return;
            end
         end
      end
   endtask

   // Monitor: every fresh egout_vld must match the oldest expected output.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && upd && egout_vld === 1'b1) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_vld: egout=%h with slot input %0d, need no output", egout, slot);
         end else begin
            int e, es;
            e  = exp_q.pop_front();
            es = exp_slot_q.pop_front();
            if (egout !== 13'(e)) begin
               n_fail++;
               $display("FAIL egout_slot%0d: got %h, need %h", es, egout, 13'(e));
            end
         end
      end
   end

   initial begin
      reset_n = 1'b1;
      model_reset();
      for (int s = 0; s < NSLOT; s++) p_key[s] = 0;
      #1 reset_n = 1'b0;
      @(negedge clk);
      n_chk++;
      if (egout !== 13'h1FFF) begin
         n_fail++; $display("FAIL reset_egout: got %h, need 1fff", egout);
      end
      n_chk++;
      if (egout_vld !== 1'b0) begin
         n_fail++; $display("FAIL reset_vld: got %b, need 0", egout_vld);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;

      for (int f = 0; f < NF_MAIN; f++) begin
         set_frame_params(f, 1'b0);
         run_frame(-1);
      end

      set_frame_params(0, 1'b1);
      run_frame(9);

      for (int f = 0; f < NF_POST; f++) begin
         set_frame_params(f, 1'b1);
         run_frame(-1);
      end

      clkena = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL drain: %0d outputs never seen, need 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
